// File: rtl/wb_burst_master.sv
// Wishbone B3 burst master: one command at a time, classic single cycle or linear
// incrementing burst, write beats pulled from a stream and read beats pushed to one.
module wb_burst_master #(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned LENW        = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [AW-1:0]     cmd_addr_i,
  input  logic              cmd_we_i,
  input  logic [LENW-1:0]   cmd_len_i,
  input  logic [DW/8-1:0]   cmd_sel_i,
  input  logic              wr_valid_i,
  input  logic [DW-1:0]     wr_data_i,
  output logic              wr_ready_o,
  output logic              rd_valid_o,
  output logic [DW-1:0]     rd_data_o,
  output logic              done_o,
  output logic              done_err_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [AW-1:0]     wb_addr_o,
  output logic [DW-1:0]     wb_dat_o,
  output logic [DW/8-1:0]   wb_sel_o,
  output logic [2:0]        wb_cti_o,
  output logic [1:0]        wb_bte_o,
  input  logic [DW-1:0]     wb_dat_i,
  input  logic              wb_ack_i
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [1:0] {IDLE, LOAD, BUS, DONE} state_t;

  state_t            state_q, state_d;
  logic [LENW-1:0]   beats_q, beats_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              err_q, err_d;

  logic              cmd_ready_d, wr_ready_d, rd_valid_d, done_d, done_err_d;
  logic              cyc_d, stb_d, we_d;
  logic [DW-1:0]     rd_data_d, dat_d;
  logic [AW-1:0]     addr_d;
  logic [SW-1:0]     sel_d;
  logic [2:0]        cti_d;

  logic              bus_ack;
  logic [LENW-1:0]   beats_dec;

  // Only an ack against a live strobe counts.
  assign bus_ack   = wb_stb_o & wb_ack_i;
  assign beats_dec = beats_q - LENW'(1);
  assign wb_bte_o  = 2'b00;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    beats_d     = beats_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    cmd_ready_d = cmd_ready_o;
    wr_ready_d  = wr_ready_o;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_o;
    done_d      = 1'b0;
    done_err_d  = 1'b0;
    cyc_d       = wb_cyc_o;
    stb_d       = wb_stb_o;
    we_d        = wb_we_o;
    addr_d      = wb_addr_o;
    dat_d       = wb_dat_o;
    sel_d       = wb_sel_o;
    cti_d       = wb_cti_o;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid_i && cmd_ready_o) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr_i;
          we_d        = cmd_we_i;
          sel_d       = cmd_sel_i;
          beats_d     = cmd_len_i;
          tmo_d       = '0;
          err_d       = 1'b0;
          cti_d       = (cmd_len_i == LENW'(1)) ? CTI_CLASSIC : CTI_INCR;
          if (cmd_len_i == '0) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (cmd_we_i) begin
            wr_ready_d = 1'b1;
            state_d    = LOAD;
          end else begin
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            state_d = BUS;
          end
        end
      end

      LOAD: begin
        if (wr_valid_i && wr_ready_o) begin
          dat_d      = wr_data_i;
          cyc_d      = 1'b1;
          stb_d      = 1'b1;
          wr_ready_d = 1'b0;
          tmo_d      = '0;
          state_d    = BUS;
        end
      end

      BUS: begin
        if (bus_ack) begin
          addr_d  = wb_addr_o + AW'(SW);
          beats_d = beats_dec;
          tmo_d   = '0;
          if (!wb_we_o) begin
            rd_data_d  = wb_dat_i;
            rd_valid_d = 1'b1;
          end
          if (beats_q == LENW'(1)) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            err_d   = 1'b0;
            state_d = DONE;
          end else begin
            // More than one beat left implies a burst, so CTI is incrementing or end.
            cti_d = (beats_dec == LENW'(1)) ? CTI_END : CTI_INCR;
            if (wb_we_o) begin
              stb_d      = 1'b0;
              wr_ready_d = 1'b1;
              state_d    = LOAD;
            end
          end
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      DONE: begin
        done_d      = 1'b1;
        done_err_d  = err_q;
        cmd_ready_d = 1'b1;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= IDLE;
      beats_q     <= '0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      cmd_ready_o <= 1'b0;
      wr_ready_o  <= 1'b0;
      rd_valid_o  <= 1'b0;
      rd_data_o   <= '0;
      done_o      <= 1'b0;
      done_err_o  <= 1'b0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_addr_o   <= '0;
      wb_dat_o    <= '0;
      wb_sel_o    <= '0;
      wb_cti_o    <= 3'b000;
    end else begin
      state_q     <= state_d;
      beats_q     <= beats_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      cmd_ready_o <= cmd_ready_d;
      wr_ready_o  <= wr_ready_d;
      rd_valid_o  <= rd_valid_d;
      rd_data_o   <= rd_data_d;
      done_o      <= done_d;
      done_err_o  <= done_err_d;
      wb_cyc_o    <= cyc_d;
      wb_stb_o    <= stb_d;
      wb_we_o     <= we_d;
      wb_addr_o   <= addr_d;
      wb_dat_o    <= dat_d;
      wb_sel_o    <= sel_d;
      wb_cti_o    <= cti_d;
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Bench for wb_burst_master: table of directed commands, a mid-burst reset sequence and
// randomized commands, all checked against a transaction-level model of the bus rules.
module tb_wb_burst_master;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned LENW = 4;
  localparam int unsigned SW   = 4;
  localparam int unsigned TMO  = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0]   cmd_addr;
  logic [LENW-1:0] cmd_len;
  logic [SW-1:0]   cmd_sel;
  logic            wr_valid, wr_ready, rd_valid, done, done_err;
  logic [DW-1:0]   wr_data, rd_data;
  logic            wb_cyc, wb_stb, wb_we, wb_ack;
  logic [AW-1:0]   wb_addr;
  logic [DW-1:0]   wb_dat_o, wb_dat_i;
  logic [SW-1:0]   wb_sel;
  logic [2:0]      wb_cti;
  logic [1:0]      wb_bte;

  always #5 clk = ~clk;

  wb_burst_master #(.AW(AW), .DW(DW), .LENW(LENW), .TIMEOUT_CYC(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_addr_i(cmd_addr),
    .cmd_we_i(cmd_we), .cmd_len_i(cmd_len), .cmd_sel_i(cmd_sel),
    .wr_valid_i(wr_valid), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data), .done_o(done), .done_err_o(done_err),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_addr_o(wb_addr),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel), .wb_cti_o(wb_cti), .wb_bte_o(wb_bte),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] slave_word(input logic [31:0] a);
    return a ^ 32'hC3A5_5A3C;
  endfunction

  // Command under test and its stimulus plan.
  logic [AW-1:0]   c_addr;
  logic            c_we;
  logic [LENW-1:0] c_len;
  logic [SW-1:0]   c_sel;
  int              waits[16];
  logic [31:0]     wdata[16];
  int              abort_at, gap_beat, gap_len;
  bit              spurious;

  // Observations of one command.
  logic [31:0] ob_addr[$], ob_wdat[$], ob_rd[$];
  logic [2:0]  ob_cti[$];
  logic [3:0]  ob_sel[$];
  logic        ob_we[$];
  logic [1:0]  ob_bte[$];
  int          ob_stb, ob_cyc_rise, ob_cyc_idle, ob_wr_hs, ob_done_ofs;
  bit          ob_done, ob_err;

  task automatic run_cmd(input logic [31:0] a, input logic we, input logic [3:0] len,
                         input logic [3:0] sel);
    int  acc_k, beat, wcnt, widx, gcnt;
    bit  accepted, prev_cyc;
    c_addr = a; c_we = we; c_len = len; c_sel = sel;
    ob_addr.delete(); ob_wdat.delete(); ob_rd.delete(); ob_cti.delete();
    ob_sel.delete(); ob_we.delete(); ob_bte.delete();
    ob_stb = 0; ob_cyc_rise = 0; ob_cyc_idle = 0; ob_wr_hs = 0; ob_done_ofs = -1;
    ob_done = 0; ob_err = 0;
    acc_k = -1; beat = 0; wcnt = 0; widx = 0; gcnt = 0; accepted = 0; prev_cyc = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!accepted) begin
        cmd_valid = 1'b1; cmd_addr = a; cmd_we = we; cmd_len = len; cmd_sel = sel;
        if (cmd_ready) begin accepted = 1; acc_k = k; end
      end else begin
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
      end
      if (wb_cyc && !prev_cyc) ob_cyc_rise++;
      prev_cyc = wb_cyc;
      if (wb_cyc && !wb_stb) ob_cyc_idle++;
      if (rd_valid) ob_rd.push_back(rd_data);
      // Slave: ack after waits[beat] stalled cycles, never for beats at or past abort_at.
      if (wb_stb) begin
        ob_stb++;
        if (beat < abort_at && wcnt >= waits[beat]) begin
          wb_ack = 1'b1;
          wb_dat_i = slave_word(wb_addr);
          ob_addr.push_back(wb_addr); ob_cti.push_back(wb_cti); ob_wdat.push_back(wb_dat_o);
          ob_sel.push_back(wb_sel); ob_we.push_back(wb_we); ob_bte.push_back(wb_bte);
          beat++; wcnt = 0;
        end else begin
          wb_ack = 1'b0; wb_dat_i = $urandom; wcnt++;
        end
      end else begin
        wb_ack   = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
        wb_dat_i = $urandom;
      end
      // Write stream, with an optional stall of gap_len ready cycles before beat gap_beat.
      if (we) begin
        if (wr_ready && widx == gap_beat && gcnt < gap_len) begin
          wr_valid = 1'b0; gcnt++;
        end else begin
          wr_valid = (widx < int'(len));
          wr_data  = (widx < 16) ? wdata[widx] : 32'h0;
        end
      end else begin
        wr_valid = 1'($urandom_range(0, 1));
        wr_data  = $urandom;
      end
      if (wr_valid && wr_ready) begin ob_wr_hs++; widx++; end
      if (done) begin
        ob_done = 1; ob_err = done_err; ob_done_ofs = k - acc_k;
        break;
      end
    end
    cmd_valid = 1'b0;
    wb_ack    = 1'b0;
    wr_valid  = 1'b0;
    check("done_seen", 64'(ob_done), 64'd1);
  endtask

  // Reference: what the bus must show for the command, from the transfer rules alone.
  task automatic verify_model(input string tag);
    bit aborted;
    int n_ack, s_sum, exp_hs, phases, exp_idle, first_load, n_rd;
    logic [31:0] ea;
    logic [2:0]  ecti;
    aborted = (c_len != 0) && (abort_at < int'(c_len));
    n_ack   = (c_len == 0) ? 0 : (aborted ? abort_at : int'(c_len));
    s_sum   = 0;
    for (int i = 0; i < n_ack; i++) s_sum += waits[i] + 1;
    if (aborted) s_sum += TMO;
    check({tag, "_beats"}, 64'(ob_addr.size()), 64'(n_ack));
    for (int i = 0; i < n_ack && i < ob_addr.size(); i++) begin
      ea   = c_addr + 32'(i * SW);
      ecti = (c_len == 1) ? 3'b000 : ((i == int'(c_len) - 1) ? 3'b111 : 3'b010);
      check($sformatf("%s_b%0d_addr", tag, i), 64'(ob_addr[i]), 64'(ea));
      check($sformatf("%s_b%0d_cti", tag, i), 64'(ob_cti[i]), 64'(ecti));
      check($sformatf("%s_b%0d_ctl", tag, i), 64'({ob_sel[i], ob_we[i], ob_bte[i]}),
            64'({c_sel, c_we, 2'b00}));
      if (c_we) check($sformatf("%s_b%0d_wdat", tag, i), 64'(ob_wdat[i]), 64'(wdata[i]));
    end
    n_rd = c_we ? 0 : n_ack;
    check({tag, "_rd_count"}, 64'(ob_rd.size()), 64'(n_rd));
    for (int i = 0; i < n_rd && i < ob_rd.size(); i++)
      check($sformatf("%s_rd%0d", tag, i), 64'(ob_rd[i]), 64'(slave_word(c_addr + 32'(i * SW))));
    exp_hs     = (!c_we || c_len == 0) ? 0 : (aborted ? abort_at + 1 : int'(c_len));
    phases     = (!c_we || c_len == 0) ? 0 : (aborted ? abort_at : int'(c_len) - 1);
    exp_idle   = phases + ((gap_beat >= 1 && gap_beat <= phases) ? gap_len : 0);
    first_load = (c_we && c_len != 0) ? 1 + ((gap_beat == 0) ? gap_len : 0) : 0;
    check({tag, "_wr_hs"}, 64'(ob_wr_hs), 64'(exp_hs));
    check({tag, "_stb_cycles"}, 64'(ob_stb), 64'(s_sum));
    check({tag, "_cyc_idle"}, 64'(ob_cyc_idle), 64'(exp_idle));
    check({tag, "_cyc_rises"}, 64'(ob_cyc_rise), 64'((c_len == 0) ? 0 : 1));
    check({tag, "_err"}, 64'(ob_err), 64'((c_len == 0) || aborted));
    check({tag, "_done_latency"}, 64'(ob_done_ofs), 64'(s_sum + exp_idle + first_load + 2));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wb_ctl"}, 64'({wb_cyc, wb_stb, wb_we, wb_sel, wb_cti, wb_bte}), 64'd0);
    check({tag, "_wb_addr"}, 64'(wb_addr), 64'd0);
    check({tag, "_wb_dat"}, 64'(wb_dat_o), 64'd0);
    check({tag, "_stream"}, 64'({wr_ready, rd_valid, done, done_err}), 64'd0);
    check({tag, "_known"}, 64'($isunknown({wb_cyc, wb_stb, wb_we, wb_addr, wb_dat_o,
                                            wb_sel, wb_cti, wb_bte})), 64'd0);
  endtask

  typedef struct {
    logic [31:0] addr; logic we; logic [3:0] len; logic [3:0] sel;
    int wait_c; int abort; int gbeat; int glen;
    int exp_stb; logic exp_err; int exp_beats;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{32'h0000_0100, 1'b0, 4'd1,  4'hF, 2, 16, -1, 0,  3, 1'b0, 1};
    vecs[1] = '{32'h0000_01FC, 1'b0, 4'd4,  4'hF, 0, 16, -1, 0,  4, 1'b0, 4};
    vecs[2] = '{32'h0000_0300, 1'b1, 4'd3,  4'h3, 0, 16,  1, 5,  3, 1'b0, 3};
    vecs[3] = '{32'h0000_0400, 1'b0, 4'd2,  4'hF, 0,  0, -1, 0,  8, 1'b1, 0};
    vecs[4] = '{32'h0000_0500, 1'b1, 4'd0,  4'hF, 0, 16, -1, 0,  0, 1'b1, 0};
    vecs[5] = '{32'hFFFF_FFF8, 1'b0, 4'd15, 4'hA, 0, 16, -1, 0, 15, 1'b0, 15};
    vecs[6] = '{32'h0000_0040, 1'b1, 4'd1,  4'h5, 1, 16, -1, 0,  2, 1'b0, 1};
    vecs[7] = '{32'h0000_0080, 1'b1, 4'd5,  4'hF, 1,  2, -1, 0, 12, 1'b1, 2};

    rst_n = 1'b0; cmd_valid = 0; cmd_addr = '0; cmd_we = 0; cmd_len = '0; cmd_sel = '0;
    wr_valid = 0; wr_data = '0; wb_ack = 0; wb_dat_i = '0; spurious = 0;
    #12;
    check_outputs_zero("reset");
    check("reset_cmd_ready", 64'(cmd_ready), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 16; i++) begin waits[i] = vecs[v].wait_c; wdata[i] = $urandom; end
      abort_at = vecs[v].abort; gap_beat = vecs[v].gbeat; gap_len = vecs[v].glen;
      run_cmd(vecs[v].addr, vecs[v].we, vecs[v].len, vecs[v].sel);
      check($sformatf("vec%0d_stb", v), 64'(ob_stb), 64'(vecs[v].exp_stb));
      check($sformatf("vec%0d_err", v), 64'(ob_err), 64'(vecs[v].exp_err));
      check($sformatf("vec%0d_beats", v), 64'(ob_addr.size()), 64'(vecs[v].exp_beats));
      verify_model($sformatf("vec%0d", v));
    end

    // Reset in the middle of a read burst while beat 2 is on the bus.
    for (int i = 0; i < 16; i++) waits[i] = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_addr = 32'h600; cmd_we = 0; cmd_len = 4'd4; cmd_sel = 4'hF;
    check("rst_seq_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk); cmd_valid = 0;
    check("rst_seq_beat1_stb", 64'({wb_cyc, wb_stb}), 64'd3);
    wb_ack = 1'b1; wb_dat_i = slave_word(wb_addr);
    @(negedge clk); wb_ack = 1'b0;
    check("rst_seq_beat2_addr", 64'({wb_stb, wb_addr}), 64'({1'b1, 32'h604}));
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("midburst_reset");
    @(negedge clk); @(negedge clk);
    check_outputs_zero("held_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("after_release_ready", 64'(cmd_ready), 64'd1);
    for (int i = 0; i < 16; i++) begin waits[i] = i % 2; wdata[i] = $urandom; end
    abort_at = 16; gap_beat = -1; gap_len = 0;
    run_cmd(32'h700, 1'b0, 4'd4, 4'hF);
    verify_model("post_reset_burst");

    // Randomized commands, with spurious acks while the strobe is low.
    for (int t = 0; t < 40; t++) begin
      logic [3:0] rl;
      rl = 4'($urandom_range(0, 15));
      for (int i = 0; i < 16; i++) begin waits[i] = $urandom_range(0, 3); wdata[i] = $urandom; end
      abort_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, int'(rl)) : 16;
      gap_beat = $urandom_range(0, int'(rl));
      gap_len  = $urandom_range(0, 4);
      spurious = 1'($urandom_range(0, 1));
      run_cmd($urandom, 1'($urandom_range(0, 1)), rl, 4'($urandom_range(0, 15)));
      verify_model($sformatf("rand%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
